pipe_hazard_ctrl: RTL and testbench

// - Stall/flush scheduler for the 5-stage forwarding pipeline.
// - Drives per-register enable/flush for IF(PC), IF/ID, ID/EX, EX/MEM and MEM/WB.
// - Resolves, in priority order: multi-cycle LSU wait > EX-stage redirect > load-use hazard.
// - Data hazards other than load-use are left to the forwarding unit.

---
 rtl/pipe_hazard_ctrl.sv | 152 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage forwarding pipeline: LSU wait > redirect > load-use.
// Optional PIPE_PERF_CNT_EN adds saturating stall/flush cycle counters.
module pipe_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [4:0] i_rs1_addr_D,
  input  logic [4:0] i_rs2_addr_D,
  input  logic       i_rs1_used_D,
  input  logic       i_rs2_used_D,
  input  logic [4:0] i_rd_addr_E,
  input  logic       i_rd_wren_E,
  input  logic       i_is_load_E,
  input  logic       i_br_taken_E,
  input  logic       i_mem_req_M,
  input  logic       i_mem_ack_M,
  output logic       o_en_F,
  output logic       o_en_D,
  output logic       o_en_E,
  output logic       o_en_M,
  output logic       o_flush_D,
  output logic       o_flush_E,
  output logic       o_flush_W,
  output logic [1:0] o_state,
  output logic       o_mem_timeout
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [31:0] o_stall_cnt,
  output logic [31:0] o_flush_cnt
`endif
);

  localparam int unsigned CntW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    StRun     = 2'b00,
    StMemWait = 2'b01,
    StTimeout = 2'b10
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              timeout_q, timeout_d;
  logic              lduse, memwait, freeze, run_eval;

  assign lduse = i_is_load_E & i_rd_wren_E & (i_rd_addr_E != 5'd0) &
                 ((i_rs1_used_D & (i_rs1_addr_D == i_rd_addr_E)) |
                  (i_rs2_used_D & (i_rs2_addr_D == i_rd_addr_E)));
  assign memwait = i_mem_req_M & ~i_mem_ack_M;

  // Next-state logic; freeze and run_eval select the output pattern below.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    freeze    = 1'b0;
    run_eval  = 1'b0;
    unique case (state_q)
      StRun: begin
        if (memwait) begin
          freeze  = 1'b1;
          cnt_d   = CntW'(1);
          state_d = StMemWait;
        end else begin
          run_eval = 1'b1;
        end
      end
      StMemWait: begin
        if (memwait) begin
          freeze = 1'b1;
          cnt_d  = cnt_q + CntW'(1);
          if (cnt_q == CntW'(MEM_TIMEOUT)) begin
            state_d   = StTimeout;
            timeout_d = 1'b1;
          end
        end else begin
          // Completion cycle behaves as RUN so held redirect/load-use applies now.
          run_eval = 1'b1;
          cnt_d    = '0;
          state_d  = StRun;
        end
      end
      StTimeout: freeze = 1'b1;
      default: begin
        state_d = StRun;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    o_en_F    = 1'b1;
    o_en_D    = 1'b1;
    o_en_E    = 1'b1;
    o_en_M    = 1'b1;
    o_flush_D = 1'b0;
    o_flush_E = 1'b0;
    o_flush_W = 1'b0;
    if (i_rst) begin
      o_en_F    = 1'b0;
      o_en_D    = 1'b0;
      o_en_E    = 1'b0;
      o_en_M    = 1'b0;
      o_flush_D = 1'b1;
      o_flush_E = 1'b1;
      o_flush_W = 1'b1;
    end else if (freeze) begin
      o_en_F    = 1'b0;
      o_en_D    = 1'b0;
      o_en_E    = 1'b0;
      o_en_M    = 1'b0;
      o_flush_W = 1'b1;
    end else if (run_eval && i_br_taken_E) begin
      // ID instruction is wrong-path, so any load-use against it is moot.
      o_flush_D = 1'b1;
      o_flush_E = 1'b1;
    end else if (run_eval && lduse) begin
      o_en_F    = 1'b0;
      o_en_D    = 1'b0;
      o_flush_E = 1'b1;
    end
  end

  assign o_state       = i_rst ? StRun : state_q;
  assign o_mem_timeout = timeout_q & ~i_rst;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= StRun;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_stall_cnt <= '0;
      o_flush_cnt <= '0;
    end else begin
      if (!o_en_F && (o_stall_cnt != 32'hFFFF_FFFF)) o_stall_cnt <= o_stall_cnt + 32'd1;
      if (o_flush_D && (o_flush_cnt != 32'hFFFF_FFFF)) o_flush_cnt <= o_flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with MEM_TIMEOUT=3; inputs change on negedge, checks follow.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs1, rs2, rd;
  logic       rs1_used, rs2_used, rd_wren, is_load, br_taken, mem_req, mem_ack;
  logic       en_f, en_d, en_e, en_m, fl_d, fl_e, fl_w;
  logic [1:0] state;
  logic       mto;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  int n_pass = 0;
  int n_tot  = 0;

  // Control vector order: {en_F, en_D, en_E, en_M, flush_D, flush_E, flush_W}
  localparam logic [6:0] CRst  = 7'b0000_111;
  localparam logic [6:0] CRun  = 7'b1111_000;
  localparam logic [6:0] CFrz  = 7'b0000_001;
  localparam logic [6:0] CRedr = 7'b1111_110;
  localparam logic [6:0] CLdu  = 7'b0011_010;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(3)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_rs1_addr_D (rs1),
    .i_rs2_addr_D (rs2),
    .i_rs1_used_D (rs1_used),
    .i_rs2_used_D (rs2_used),
    .i_rd_addr_E  (rd),
    .i_rd_wren_E  (rd_wren),
    .i_is_load_E  (is_load),
    .i_br_taken_E (br_taken),
    .i_mem_req_M  (mem_req),
    .i_mem_ack_M  (mem_ack),
    .o_en_F       (en_f),
    .o_en_D       (en_d),
    .o_en_E       (en_e),
    .o_en_M       (en_m),
    .o_flush_D    (fl_d),
    .o_flush_E    (fl_e),
    .o_flush_W    (fl_w),
    .o_state      (state),
    .o_mem_timeout(mto)
`ifdef PIPE_PERF_CNT_EN
    ,
    .o_stall_cnt  (stall_cnt),
    .o_flush_cnt  (flush_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [6:0] ctl, input logic [1:0] st,
                     input logic to);
    logic [9:0] obs, exp;
    #2;
    obs = {en_f, en_d, en_e, en_m, fl_d, fl_e, fl_w, state, mto};
    exp = {ctl, st, to};
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed ctl/state/to=%b/%b/%b required %b/%b/%b",
                tag, obs[9:3], obs[2:1], obs[0], ctl, st, to);
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0;
    rs1_used = 0; rs2_used = 0; rd_wren = 0; is_load = 0;
    br_taken = 0; mem_req = 0; mem_ack = 0;
  endtask

  task automatic set_lduse(input logic [4:0] r);
    is_load = 1; rd_wren = 1; rd = r; rs1 = r; rs1_used = 1;
  endtask

  initial begin
    idle();
    rst = 1;
    mem_req = 1;  // reset must dominate a pending LSU wait
    @(negedge clk);
    chk("reset_c1", CRst, 2'b00, 1'b0);
    cyc();
    chk("reset_c2", CRst, 2'b00, 1'b0);
    cyc();
    rst = 0; idle();
    chk("run_default", CRun, 2'b00, 1'b0);

    // Load-use via rs1, then bubble in EX clears it
    set_lduse(5'd5);
    chk("lduse_rs1", CLdu, 2'b00, 1'b0);
    cyc(); idle();
    chk("lduse_clear", CRun, 2'b00, 1'b0);
    cyc();
    is_load = 1; rd_wren = 1; rd = 5'd7; rs2 = 5'd7; rs2_used = 1; rs1 = 5'd3; rs1_used = 1;
    chk("lduse_rs2", CLdu, 2'b00, 1'b0);
    rs2_used = 0;
    chk("lduse_rs2_unused", CRun, 2'b00, 1'b0);
    cyc(); idle();
    set_lduse(5'd0);
    chk("lduse_x0", CRun, 2'b00, 1'b0);
    set_lduse(5'd9); rd_wren = 0;
    chk("lduse_nowren", CRun, 2'b00, 1'b0);
    cyc(); idle();
    set_lduse(5'd5); br_taken = 1;
    chk("redirect_over_lduse", CRedr, 2'b00, 1'b0);
    cyc(); idle();
    mem_ack = 1;
    chk("ack_without_req", CRun, 2'b00, 1'b0);
    cyc(); idle();

    // LSU wait, ack on 4th cycle, which coincides with cnt==MEM_TIMEOUT
    mem_req = 1; set_lduse(5'd5); br_taken = 1;
    chk("memwait_entry", CFrz, 2'b00, 1'b0);
    cyc(); br_taken = 0;
    chk("memwait_c2", CFrz, 2'b01, 1'b0);
    cyc();
    chk("memwait_c3", CFrz, 2'b01, 1'b0);
    cyc(); mem_ack = 1;
    chk("memwait_ack_lduse", CLdu, 2'b01, 1'b0);
    cyc(); idle();
    chk("memwait_back_run", CRun, 2'b00, 1'b0);

    // LSU wait with redirect held through to the ack cycle
    mem_req = 1; br_taken = 1;
    chk("memwait_br_entry", CFrz, 2'b00, 1'b0);
    cyc();
    chk("memwait_br_c2", CFrz, 2'b01, 1'b0);
    cyc(); mem_ack = 1;
    chk("memwait_br_ack", CRedr, 2'b01, 1'b0);
    cyc(); idle();
    chk("memwait_br_run", CRun, 2'b00, 1'b0);

    // Timeout: RUN entry + 3 wait cycles, then TIMEOUT
    mem_req = 1;
    chk("to_entry", CFrz, 2'b00, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("to_wait", CFrz, 2'b01, 1'b0);
    end
    cyc();
    chk("to_state", CFrz, 2'b10, 1'b1);
    mem_ack = 1;
    chk("to_ack_ignored", CFrz, 2'b10, 1'b1);
    cyc(); mem_req = 0; mem_ack = 0;
    chk("to_sticky", CFrz, 2'b10, 1'b1);
    cyc(); rst = 1;
    chk("to_reset", CRst, 2'b00, 1'b0);
    cyc(); rst = 0;
    chk("to_after_reset", CRun, 2'b00, 1'b0);

    // Reset during MEM_WAIT
    mem_req = 1;
    cyc();
    chk("mw_before_rst", CFrz, 2'b01, 1'b0);
    rst = 1;
    cyc(); rst = 0; idle();
    chk("mw_after_rst", CRun, 2'b00, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
